// File: rtl/traffic_light_ctrl_param_if.sv
// Sensor/lamp/debug bundle between the intersection controller and its board top.
// The controller sits on the slave side; the board or bench drives from master.
interface traffic_light_ctrl_param_if;
    logic       Sa;
    logic       Sb;
    logic       flash_en;
    logic [2:0] lightA;
    logic [2:0] lightB;
    logic       tick_disp;
    logic [2:0] state_disp;
    logic [7:0] tcnt_disp;

    modport master (
        output Sa, Sb, flash_en,
        input  lightA, lightB, tick_disp, state_disp, tcnt_disp
    );

    modport slave (
        input  Sa, Sb, flash_en,
        output lightA, lightB, tick_disp, state_disp, tcnt_disp
    );
endinterface

// File: rtl/traffic_light_ctrl_param.sv
// Two-road intersection controller with min/max green, all-red clearance and a
// flashing-yellow maintenance mode; state advances only on the internal phase tick.
module traffic_light_ctrl_param #(
    parameter int TICK_DIV    = 50000000,
    parameter int GREEN_MIN_A = 6,
    parameter int YELLOW_T    = 1,
    parameter int ALLRED_T    = 1,
    parameter int GREEN_MIN_B = 5,
    parameter int GREEN_MAX_B = 10
) (
    input logic                       clk,
    input logic                       rst,
    traffic_light_ctrl_param_if.slave bus
);
    localparam logic [2:0] S_A_GREEN  = 3'd0;
    localparam logic [2:0] S_A_YELLOW = 3'd1;
    localparam logic [2:0] S_ALLRED_AB = 3'd2;
    localparam logic [2:0] S_B_GREEN  = 3'd3;
    localparam logic [2:0] S_B_YELLOW = 3'd4;
    localparam logic [2:0] S_ALLRED_BA = 3'd5;
    localparam logic [2:0] S_FLASH    = 3'd6;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // Exit thresholds are compared against tcnt, which starts at 0 in each state.
    localparam logic [7:0] MIN_A_L  = 8'(GREEN_MIN_A - 1);
    localparam logic [7:0] YEL_L    = 8'(YELLOW_T - 1);
    localparam logic [7:0] ALLRED_L = 8'(ALLRED_T - 1);
    localparam logic [7:0] MIN_B_L  = 8'(GREEN_MIN_B - 1);
    localparam logic [7:0] MAX_B_L  = 8'(GREEN_MAX_B - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [2:0]       state_r;
    logic [7:0]       tcnt_r;
    logic             flash_phase_r;
    logic             tick_s;
    logic [2:0]       state_nxt_s;
    logic [5:0]       lamps_s;

    // Returns {lightA, lightB}; unlisted codes fall back to all-red.
    function automatic logic [5:0] lamp_decode(input logic [2:0] st, input logic ph);
        logic [5:0] l;
        case (st)
            S_A_GREEN:   l = {LAMP_G, LAMP_R};
            S_A_YELLOW:  l = {LAMP_Y, LAMP_R};
            S_B_GREEN:   l = {LAMP_R, LAMP_G};
            S_B_YELLOW:  l = {LAMP_R, LAMP_Y};
            S_FLASH:     l = ph ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
            default:     l = {LAMP_R, LAMP_R};
        endcase
        return l;
    endfunction

    assign tick_s = (div_cnt_r == DIV_LAST);

    // Next-state selection, meaningful only on tick cycles.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_A_GREEN: begin
                if ((tcnt_r >= MIN_A_L) && bus.Sb) state_nxt_s = S_A_YELLOW;
                else                               state_nxt_s = S_A_GREEN;
            end
            S_A_YELLOW: begin
                if (tcnt_r == YEL_L) state_nxt_s = S_ALLRED_AB;
                else                 state_nxt_s = S_A_YELLOW;
            end
            S_ALLRED_AB: begin
                if (tcnt_r == ALLRED_L) state_nxt_s = S_B_GREEN;
                else                    state_nxt_s = S_ALLRED_AB;
            end
            S_B_GREEN: begin
                if (tcnt_r == MAX_B_L)                                   state_nxt_s = S_B_YELLOW;
                else if ((tcnt_r >= MIN_B_L) && (bus.Sa || !bus.Sb))     state_nxt_s = S_B_YELLOW;
                else                                                     state_nxt_s = S_B_GREEN;
            end
            S_B_YELLOW: begin
                if (tcnt_r == YEL_L) state_nxt_s = S_ALLRED_BA;
                else                 state_nxt_s = S_B_YELLOW;
            end
            S_ALLRED_BA: begin
                if (tcnt_r == ALLRED_L) state_nxt_s = S_A_GREEN;
                else                    state_nxt_s = S_ALLRED_BA;
            end
            S_FLASH: begin
                if (bus.flash_en) state_nxt_s = S_FLASH;
                else              state_nxt_s = S_ALLRED_BA;
            end
            default: state_nxt_s = S_ALLRED_BA;
        endcase
        // Maintenance request wins over every normal exit in the legal road states.
        if (bus.flash_en && (state_r <= S_ALLRED_BA)) state_nxt_s = S_FLASH;
        else                                          state_nxt_s = state_nxt_s;
    end

    // Tick divider, state register, per-state tick counter and flash phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r     <= '0;
            state_r       <= S_A_GREEN;
            tcnt_r        <= 8'd0;
            flash_phase_r <= 1'b0;
        end else begin
            div_cnt_r <= tick_s ? '0 : (div_cnt_r + DIV_ONE);
            if (tick_s) begin
                state_r <= state_nxt_s;
                if (state_nxt_s != state_r) tcnt_r <= 8'd0;
                else if (tcnt_r != 8'hFF)   tcnt_r <= tcnt_r + 8'd1;
                if (state_nxt_s == S_FLASH)
                    flash_phase_r <= (state_r == S_FLASH) ? ~flash_phase_r : 1'b0;
                else
                    flash_phase_r <= 1'b0;
            end
        end
    end

    // Lamps decode straight from state so a reset shows A=G B=R at once.
    always_comb begin
        lamps_s = lamp_decode(state_r, flash_phase_r);
    end

    assign bus.lightA     = lamps_s[5:3];
    assign bus.lightB     = lamps_s[2:0];
    assign bus.tick_disp  = tick_s;
    assign bus.state_disp = state_r;
    assign bus.tcnt_disp  = tcnt_r;
endmodule
